// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares a single sram-like bus between the instruction-fetch
// port and the data-memory port, one transaction at a time. It produces the
// i_stall/d_stall signals and holds finished results until the pipeline advances.
// It also drops fetch data that was made stale by an exception redirect.
// Optional feature macro: SRAM_ARB_RR_EN (round-robin arbitration in IDLE).
module sram_bus_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // instruction fetch port
   input  logic              inst_sram_en,
   input  logic [ADDR_W-1:0] inst_sram_addr,
   output logic [31:0]       inst_sram_rdata,
   output logic              i_stall,
   // data port
   input  logic              data_sram_en,
   input  logic [3:0]        data_sram_wen,
   input  logic [ADDR_W-1:0] data_sram_addr,
   input  logic [31:0]       data_sram_wdata,
   output logic [31:0]       data_sram_rdata,
   output logic              d_stall,
   // pipeline control
   input  logic              longest_stall,
   input  logic              flush,
   // sram-like bus
   output logic              req,
   output logic              wr,
   output logic [1:0]        size,
   output logic [ADDR_W-1:0] addr,
   output logic [31:0]       wdata,
   input  logic              addr_ok,
   input  logic              data_ok,
   input  logic [31:0]       rdata
);

   typedef enum logic [2:0] {
      IDLE,
      I_ADDR,
      I_DATA,
      D_ADDR,
      D_DATA
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        i_done;
   logic        d_done;
   logic        i_discard;
   logic [31:0] i_buf;
   logic [31:0] d_buf;

   logic        i_need;
   logic        d_need;
   logic        grant_i;
   logic        grant_d;
   logic [1:0]  wen_size;
   logic        i_fin;
   logic        d_fin;
   logic        i_inflight;

`ifdef SRAM_ARB_RR_EN
   logic        last_grant;   // 1 = data port won last, 0 = fetch port won last
`endif

   assign i_need          = inst_sram_en & ~i_done;
   assign d_need          = data_sram_en & ~d_done;
   assign i_stall         = i_need;
   assign d_stall         = d_need;
   assign inst_sram_rdata = i_buf;
   assign data_sram_rdata = d_buf;

   assign i_fin      = (state == I_DATA) & data_ok;
   assign d_fin      = (state == D_DATA) & data_ok;
   assign i_inflight = (state == I_ADDR) | (state == I_DATA);

   // Choose which port gets the bus; this only matters while the FSM is in IDLE.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state == IDLE) begin
`ifdef SRAM_ARB_RR_EN
         if (d_need && i_need) begin
            grant_d = ~last_grant;
            grant_i = last_grant;
         end else begin
            grant_d = d_need;
            grant_i = i_need;
         end
`else
         grant_d = d_need;
         grant_i = i_need & ~d_need;
`endif
      end
   end

   // Decode the byte strobes into a bus transfer size.
   always_comb begin
      case (data_sram_wen)
         4'b1111, 4'b0000:                   wen_size = 2'd2;
         4'b0011, 4'b1100:                   wen_size = 2'd1;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: wen_size = 2'd0;
         default:                            wen_size = 2'd2;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_d)      state_nxt = D_ADDR;
            else if (grant_i) state_nxt = I_ADDR;
         end
         I_ADDR:  if (addr_ok) state_nxt = I_DATA;
         I_DATA:  if (data_ok) state_nxt = IDLE;
         D_ADDR:  if (addr_ok) state_nxt = D_DATA;
         D_DATA:  if (data_ok) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: the request is decoded from state alone, so CPU inputs never reach the bus combinationally.
   always_comb begin
      req = (state == I_ADDR) | (state == D_ADDR);
   end

   // Latch the winning request's bus fields when the grant is made.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr    <= 1'b0;
         size  <= 2'd0;
         addr  <= '0;
         wdata <= '0;
      end else if (grant_d) begin
         wr    <= |data_sram_wen;
         size  <= wen_size;
         addr  <= data_sram_addr;
         wdata <= data_sram_wdata;
      end else if (grant_i) begin
         wr    <= 1'b0;
         size  <= 2'd2;
         addr  <= inst_sram_addr;
         wdata <= '0;
      end
   end

   // Fetch completion, hold, and stale-fetch discard.
   // A flush that lands on the completing edge also counts as the discard.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_done    <= 1'b0;
         i_discard <= 1'b0;
         i_buf     <= '0;
      end else begin
         if (i_fin && !i_discard && !flush) begin
            i_done <= 1'b1;
            i_buf  <= rdata;
         end else if (flush || !longest_stall) begin
            i_done <= 1'b0;
         end
         if (i_fin)                     i_discard <= 1'b0;
         else if (flush && i_inflight)  i_discard <= 1'b1;
      end
   end

   // Data completion and hold. A data transfer always completes, even during a flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_done <= 1'b0;
         d_buf  <= '0;
      end else if (d_fin) begin
         d_done <= 1'b1;
         d_buf  <= rdata;
      end else if (flush || !longest_stall) begin
         d_done <= 1'b0;
      end
   end

`ifdef SRAM_ARB_RR_EN
   // Remember the last winner so that a tie goes to the other port.
   always_ff @(posedge clk) begin
      if (rst)          last_grant <= 1'b0;
      else if (grant_d) last_grant <= 1'b1;
      else if (grant_i) last_grant <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed, table-driven bench for sram_bus_arbiter.
// The bench plays the role of the bus bridge cycle by cycle. Inputs change 1ns
// after each rising edge, and outputs are checked 1ns after that.
module tb_sram_bus_arbiter;

   logic        clk;
   logic        rst;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        i_stall;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        d_stall;
   logic        longest_stall;
   logic        flush;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   int unsigned n_cmp;
   int unsigned n_bad;

   sram_bus_arbiter #(.ADDR_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdata (inst_sram_rdata),
      .i_stall         (i_stall),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .d_stall         (d_stall),
      .longest_stall   (longest_stall),
      .flush           (flush),
      .req             (req),
      .wr              (wr),
      .size            (size),
      .addr            (addr),
      .wdata           (wdata),
      .addr_ok         (addr_ok),
      .data_ok         (data_ok),
      .rdata           (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  wen;
      logic [31:0] a;
      logic [31:0] wd;
      logic        exp_wr;
      logic [1:0]  exp_size;
      int unsigned wait_n;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      inst_sram_en = 1'b0; inst_sram_addr = '0;
      data_sram_en = 1'b0; data_sram_wen = '0; data_sram_addr = '0; data_sram_wdata = '0;
      longest_stall = 1'b0; flush = 1'b0;
      addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   // Called 1ns after the edge that enters an ADDR state. It checks the request
   // fields while the request is held, accepts it after nw extra cycles, and then
   // returns data. It returns 1ns after the edge that completes the transfer.
   task automatic serve(input logic [31:0] ea, input logic ew, input logic [1:0] es,
                        input logic [31:0] ewd, input int unsigned nw,
                        input logic [31:0] rd, input string tag);
      for (int unsigned w = 0; w <= nw; w++) begin
         #1;
         chk({tag, ".req"},   32'(req),  32'd1);
         chk({tag, ".addr"},  addr,      ea);
         chk({tag, ".wr"},    32'(wr),   32'(ew));
         chk({tag, ".size"},  32'(size), 32'(es));
         chk({tag, ".wdata"}, wdata,     ewd);
         addr_ok = (w == nw);
         next_cycle();
      end
      addr_ok = 1'b0;
      data_ok = 1'b1;
      rdata   = rd;
      #1;
      chk({tag, ".req_data"}, 32'(req), 32'd0);
      next_cycle();
      data_ok = 1'b0;
      rdata   = 32'h5A5A5A5A;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      tbl[0] = '{4'b0100, 32'h80002000, 32'h00AB0000, 1'b1, 2'd0, 3, 32'h0000_0000};
      tbl[1] = '{4'b1111, 32'h80002004, 32'hDEADBEEF, 1'b1, 2'd2, 0, 32'h0101_0101};
      tbl[2] = '{4'b0011, 32'h80002008, 32'h00001234, 1'b1, 2'd1, 1, 32'h0202_0202};
      tbl[3] = '{4'b1100, 32'h8000200A, 32'h56780000, 1'b1, 2'd1, 0, 32'h0303_0303};
      tbl[4] = '{4'b0001, 32'h8000200C, 32'h000000CD, 1'b1, 2'd0, 2, 32'h0404_0404};
      tbl[5] = '{4'b0000, 32'h80002010, 32'h00000000, 1'b0, 2'd2, 0, 32'hAABBCCDD};

      // Check the state while reset is held, with a fetch already requested.
      do_reset();
      rst = 1'b1;
      inst_sram_en = 1'b1;
      next_cycle();
      next_cycle();
      #1;
      chk("rst.req",    32'(req),  32'd0);
      chk("rst.wr",     32'(wr),   32'd0);
      chk("rst.size",   32'(size), 32'd0);
      chk("rst.addr",   addr,      32'd0);
      chk("rst.wdata",  wdata,     32'd0);
      chk("rst.i_stall", 32'(i_stall), 32'd1);
      chk("rst.d_stall", 32'(d_stall), 32'd0);
      chk("rst.irdata", inst_sram_rdata, 32'd0);
      chk("rst.drdata", data_sram_rdata, 32'd0);

      // Fetch only, followed by a hold and then a release.
      do_reset();
      longest_stall = 1'b1;
      next_cycle();                                   // c0
      inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00000;
      #1;
      chk("f.c0_req",    32'(req),     32'd0);
      chk("f.c0_istall", 32'(i_stall), 32'd1);
      next_cycle();                                   // c1
      serve(32'hBFC00000, 1'b0, 2'd2, 32'd0, 0, 32'h24080001, "f");
      #1;                                             // c3
      chk("f.c3_istall", 32'(i_stall), 32'd0);
      chk("f.c3_rdata",  inst_sram_rdata, 32'h24080001);
      for (int k = 0; k < 4; k++) begin
         if (k != 0) begin
            next_cycle();
            #1;
         end
         chk("hold.req",    32'(req),     32'd0);
         chk("hold.istall", 32'(i_stall), 32'd0);
         chk("hold.rdata",  inst_sram_rdata, 32'h24080001);
      end
      next_cycle();
      longest_stall = 1'b0;
      #1;
      chk("rel.istall_same", 32'(i_stall), 32'd0);
      next_cycle();
      longest_stall = 1'b1;
      #1;
      chk("rel.istall_next", 32'(i_stall), 32'd1);
      chk("rel.req_idle",    32'(req),     32'd0);
      next_cycle();
      #1;
      chk("rel.req_new",     32'(req),     32'd1);

      // A load and a fetch requested in the same cycle.
      do_reset();
      longest_stall = 1'b1;
      next_cycle();                                   // c0
      inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00004;
      data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h80001000;
      #1;
      chk("tie.c0_req",    32'(req),     32'd0);
      chk("tie.c0_dstall", 32'(d_stall), 32'd1);
      next_cycle();                                   // c1
      serve(32'h80001000, 1'b0, 2'd2, 32'd0, 0, 32'h11112222, "tie_d");
      #1;                                             // c3
      chk("tie.c3_dstall", 32'(d_stall), 32'd0);
      chk("tie.c3_istall", 32'(i_stall), 32'd1);
      chk("tie.c3_drdata", data_sram_rdata, 32'h11112222);
      next_cycle();                                   // c4
      serve(32'hBFC00004, 1'b0, 2'd2, 32'd0, 0, 32'h33334444, "tie_i");
      #1;                                             // c6
      chk("tie.c6_istall", 32'(i_stall), 32'd0);
      chk("tie.c6_irdata", inst_sram_rdata, 32'h33334444);
      chk("tie.c6_dstall", 32'(d_stall), 32'd0);

      // A tie right after a data-only grant.
      do_reset();
      longest_stall = 1'b1;
      next_cycle();
      data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h80001000;
      next_cycle();
      serve(32'h80001000, 1'b0, 2'd2, 32'd0, 0, 32'h0A0A0A0A, "pre_d");
      #1;
      chk("pre.dstall", 32'(d_stall), 32'd0);
      data_sram_en = 1'b0;
      longest_stall = 1'b0;
      next_cycle();
      longest_stall = 1'b1;
      data_sram_en = 1'b1; data_sram_addr = 32'h80001040;
      inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00010;
      #1;
      chk("tie2.c0_req", 32'(req), 32'd0);
      next_cycle();
`ifdef SRAM_ARB_RR_EN
      serve(32'hBFC00010, 1'b0, 2'd2, 32'd0, 0, 32'h0B0B0B0B, "tie2_i");
      #1;
      chk("tie2.istall_first", 32'(i_stall), 32'd0);
      chk("tie2.dstall_first", 32'(d_stall), 32'd1);
      next_cycle();
      serve(32'h80001040, 1'b0, 2'd2, 32'd0, 0, 32'h0C0C0C0C, "tie2_d");
      #1;
      chk("tie2.dstall_last", 32'(d_stall), 32'd0);
      chk("tie2.drdata",      data_sram_rdata, 32'h0C0C0C0C);
`else
      serve(32'h80001040, 1'b0, 2'd2, 32'd0, 0, 32'h0C0C0C0C, "tie2_d");
      #1;
      chk("tie2.dstall_first", 32'(d_stall), 32'd0);
      chk("tie2.istall_first", 32'(i_stall), 32'd1);
      next_cycle();
      serve(32'hBFC00010, 1'b0, 2'd2, 32'd0, 0, 32'h0B0B0B0B, "tie2_i");
      #1;
      chk("tie2.istall_last", 32'(i_stall), 32'd0);
      chk("tie2.irdata",      inst_sram_rdata, 32'h0B0B0B0B);
`endif

      // Table of data-port accesses: size encoding, write flag, and a held request.
      do_reset();
      for (int unsigned v = 0; v < 6; v++) begin
         next_cycle();
         longest_stall = 1'b1;
         data_sram_en = 1'b1;
         data_sram_wen = tbl[v].wen;
         data_sram_addr = tbl[v].a;
         data_sram_wdata = tbl[v].wd;
         #1;
         chk($sformatf("vec%0d.c0_req", v),    32'(req),     32'd0);
         chk($sformatf("vec%0d.c0_dstall", v), 32'(d_stall), 32'd1);
         next_cycle();
         serve(tbl[v].a, tbl[v].exp_wr, tbl[v].exp_size, tbl[v].wd, tbl[v].wait_n,
               tbl[v].rd, $sformatf("vec%0d", v));
         #1;
         chk($sformatf("vec%0d.dstall", v), 32'(d_stall), 32'd0);
         chk($sformatf("vec%0d.drdata", v), data_sram_rdata, tbl[v].rd);
         data_sram_en = 1'b0;
         longest_stall = 1'b0;
         next_cycle();
      end

      // Flush during I_DATA, with data_ok arriving one cycle later.
      do_reset();
      longest_stall = 1'b1;
      next_cycle();                                   // c0
      inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00000;
      next_cycle();                                   // c1
      #1;
      chk("fl.c1_req", 32'(req), 32'd1);
      addr_ok = 1'b1;
      next_cycle();                                   // c2 I_DATA
      addr_ok = 1'b0;
      flush = 1'b1;
      #1;
      chk("fl.c2_req", 32'(req), 32'd0);
      next_cycle();                                   // c3 still I_DATA
      flush = 1'b0;
      inst_sram_addr = 32'hBFC00380;
      data_ok = 1'b1; rdata = 32'hDEADDEAD;
      #1;
      chk("fl.c3_istall", 32'(i_stall), 32'd1);
      next_cycle();                                   // c4 IDLE
      data_ok = 1'b0;
      #1;
      chk("fl.c4_istall", 32'(i_stall), 32'd1);
      chk("fl.c4_irdata", inst_sram_rdata, 32'd0);
      chk("fl.c4_req",    32'(req), 32'd0);
      next_cycle();                                   // c5 I_ADDR
      serve(32'hBFC00380, 1'b0, 2'd2, 32'd0, 0, 32'h3C1A0000, "fl_new");
      #1;
      chk("fl.new_istall", 32'(i_stall), 32'd0);
      chk("fl.new_irdata", inst_sram_rdata, 32'h3C1A0000);

      // flush and data_ok in the same I_DATA cycle: the data is dropped and the discard flag ends cleared.
      do_reset();
      longest_stall = 1'b1;
      next_cycle();
      inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00000;
      next_cycle();
      addr_ok = 1'b1;
      next_cycle();                                   // I_DATA
      addr_ok = 1'b0;
      flush = 1'b1; data_ok = 1'b1; rdata = 32'hBADBAD00;
      next_cycle();                                   // IDLE
      flush = 1'b0; data_ok = 1'b0;
      inst_sram_addr = 32'hBFC00380;
      #1;
      chk("fs.istall",  32'(i_stall), 32'd1);
      chk("fs.irdata",  inst_sram_rdata, 32'd0);
      next_cycle();
      serve(32'hBFC00380, 1'b0, 2'd2, 32'd0, 0, 32'h77778888, "fs_new");
      #1;
      chk("fs.new_istall", 32'(i_stall), 32'd0);
      chk("fs.new_irdata", inst_sram_rdata, 32'h77778888);

      // Reset asserted while in D_ADDR.
      do_reset();
      longest_stall = 1'b1;
      next_cycle();
      data_sram_en = 1'b1; data_sram_wen = 4'b1111;
      data_sram_addr = 32'h80003000; data_sram_wdata = 32'h12345678;
      next_cycle();                                   // D_ADDR
      #1;
      chk("rd.req_before", 32'(req), 32'd1);
      rst = 1'b1;
      next_cycle();
      #1;
      chk("rd.req",     32'(req),  32'd0);
      chk("rd.wr",      32'(wr),   32'd0);
      chk("rd.size",    32'(size), 32'd0);
      chk("rd.addr",    addr,      32'd0);
      chk("rd.wdata",   wdata,     32'd0);
      chk("rd.dstall",  32'(d_stall), 32'd1);
      rst = 1'b0;
      data_sram_en = 1'b0;
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
